// File: rtl/arb_mux_reg_if.sv
// arb_mux_reg_if: handshake and payload bundle for the arbitrated N-to-1 register mux.
//   mode       arbitration mode (00 RR, 01/11 fixed priority, 10 forced select)
//   sel        forced-select channel index
//   in_valid   per-channel request valid
//   in_data    flattened channel payloads, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_ready   per-channel accept (at most one bit set)
//   out_valid  output register holds a word
//   out_data   registered payload
//   out_ch     source channel of out_data
//   out_ready  downstream accept
// modport master: the requesters and downstream consumer side; modport slave: the mux.
interface arb_mux_reg_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_CH     = 16
);
    localparam int unsigned SEL_WIDTH = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [1:0]                     mode;
    logic [SEL_WIDTH-1:0]           sel;
    logic [NUM_CH-1:0]              in_valid;
    logic [NUM_CH*DATA_WIDTH-1:0]   in_data;
    logic [NUM_CH-1:0]              in_ready;
    logic                           out_valid;
    logic [DATA_WIDTH-1:0]          out_data;
    logic [SEL_WIDTH-1:0]           out_ch;
    logic                           out_ready;

    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/arb_mux_reg.sv
// arb_mux_reg: parametrised N-to-1 valid/ready mux with built-in arbiter and a
// one-entry, bubble-free registered output stage.
//   clk  system clock, all state on rising edge
//   rst  synchronous reset, active-high
//   bus  arb_mux_reg_if.slave (mode, sel, in_valid, in_data, in_ready,
//        out_valid, out_data, out_ch, out_ready)
module arb_mux_reg #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_CH     = 16
) (
    input  logic          clk,
    input  logic          rst,
    arb_mux_reg_if.slave  bus
);
    localparam int unsigned SEL_WIDTH = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [SEL_WIDTH-1:0]  out_ch_q;
    logic [SEL_WIDTH-1:0]  ptr_q;

    logic                  load_en_c;
    logic                  found_c;
    logic [SEL_WIDTH-1:0]  gidx_c;
    logic [NUM_CH-1:0]     grant_c;
    logic                  xfer_c;
    int unsigned           idx_c;
    logic [DATA_WIDTH-1:0] ch_data [NUM_CH];

    // Unflatten channel payloads so the selected word can be indexed directly.
    for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_unpack
        assign ch_data[i] = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Stage can accept when empty or when the held word leaves this cycle.
    assign load_en_c = !out_valid_q || bus.out_ready;

    // Arbitration search: picks the winning channel index, independent of load_en.
    always_comb begin
        found_c = 1'b0;
        gidx_c  = '0;
        idx_c   = 0;
        case (bus.mode)
            2'b00: begin
                // Round-robin: scan ptr, ptr+1, ... wrapping at NUM_CH.
                for (int unsigned k = 0; k < NUM_CH; k++) begin
                    idx_c = 32'(ptr_q) + k;
                    if (idx_c >= NUM_CH) begin
                        idx_c = idx_c - NUM_CH;
                    end
                    if (!found_c && bus.in_valid[SEL_WIDTH'(idx_c)]) begin
                        found_c = 1'b1;
                        gidx_c  = SEL_WIDTH'(idx_c);
                    end
                end
            end
            2'b10: begin
                // Forced select; out-of-range indices never grant.
                if ((32'(bus.sel) < NUM_CH) && bus.in_valid[bus.sel]) begin
                    found_c = 1'b1;
                    gidx_c  = bus.sel;
                end
            end
            default: begin
                // Fixed priority, lowest index wins.
                for (int unsigned k = 0; k < NUM_CH; k++) begin
                    if (!found_c && bus.in_valid[SEL_WIDTH'(k)]) begin
                        found_c = 1'b1;
                        gidx_c  = SEL_WIDTH'(k);
                    end
                end
            end
        endcase
    end

    // Grant is one-hot, gated by stage availability and held off during reset.
    assign xfer_c = found_c && load_en_c && !rst;

    always_comb begin
        grant_c = '0;
        if (xfer_c) begin
            grant_c[gidx_c] = 1'b1;
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            if (xfer_c) begin
                out_valid_q <= 1'b1;
                out_data_q  <= ch_data[gidx_c];
                out_ch_q    <= gidx_c;
                if (bus.mode == 2'b00) begin
                    ptr_q <= (32'(gidx_c) == NUM_CH - 1) ? '0 : gidx_c + SEL_WIDTH'(1);
                end
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = grant_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
endmodule
